// File: rtl/byte_unstriping_n.sv
// Round-robin byte un-striper: LANES skewed byte lanes, each behind a small
// elastic FIFO, merged into one ordered stream with downstream backpressure.
module byte_unstriping_n #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_f,
  input  logic                       reset,
  input  logic [LANES*WIDTH-1:0]     lane_data,
  input  logic [LANES-1:0]           lane_valid,
  input  logic [3:0]                 active_lanes,
  input  logic                       ready_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid_out,
  output logic [$clog2(LANES)-1:0]   lane_sel,
  output logic [LANES-1:0]           overflow
);

  localparam int SEL_W = $clog2(LANES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // 0 or anything beyond the physical lane count means "all lanes".
  function automatic logic [3:0] f_decode(input logic [3:0] n);
    if (n == 4'd0 || n > 4'(LANES)) return 4'(LANES);
    return n;
  endfunction

  logic [3:0]             r_active;
  logic                   r_first;
  logic [SEL_W-1:0]       r_lane_sel;
  logic [WIDTH-1:0]       r_data;
  logic                   r_valid;

  logic [3:0]             w_act;
  logic                   w_pop;
  logic                   w_wrap;
  logic [LANES-1:0]       w_nonempty;
  logic [LANES*WIDTH-1:0] w_heads;
  logic [WIDTH-1:0]       w_head;

  // The first edge after reset release uses the live count, then latches it.
  assign w_act  = r_first ? f_decode(active_lanes) : r_active;
  assign w_pop  = w_nonempty[r_lane_sel] && (!r_valid || ready_in);
  assign w_wrap = (r_lane_sel == SEL_W'(w_act - 4'd1));
  assign w_head = w_heads[r_lane_sel*WIDTH +: WIDTH];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_push_req;
    logic             w_pop_lane;
    logic             w_full;
    logic             w_push;

    assign w_push_req = lane_valid[g] && (4'(g) < w_act);
    assign w_pop_lane = w_pop && (r_lane_sel == SEL_W'(g));
    assign w_full     = (r_cnt == CNT_W'(DEPTH));
    assign w_push     = w_push_req && (!w_full || w_pop_lane);

    // NOTE: FIFO storage is deliberately not reset; the cleared count marks
    // every entry invalid, and a resettable RAM would cost a flop per bit.
    always_ff @(posedge clk_f) begin
      if (w_push) r_mem[r_wr_ptr] <= lane_data[g*WIDTH +: WIDTH];
    end

    // NOTE: state registers use non-blocking assignments so every block
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_f or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop_lane) r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop_lane})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
        if (w_push_req && !w_push) r_ovf <= 1'b1;
      end
    end

    assign w_heads[g*WIDTH +: WIDTH] = r_mem[r_rd_ptr];
    assign w_nonempty[g]             = (r_cnt != '0);
    assign overflow[g]               = r_ovf;
  end

  always_ff @(posedge clk_f or negedge reset) begin
    if (!reset) begin
      r_active   <= 4'(LANES);
      r_first    <= 1'b1;
      r_lane_sel <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_first <= 1'b0;
      if (r_first) r_active <= f_decode(active_lanes);
      if (w_pop) begin
        r_data  <= w_head;
        r_valid <= 1'b1;
        if (w_wrap) begin
          r_lane_sel <= '0;
          r_active   <= f_decode(active_lanes);
        end else begin
          r_lane_sel <= r_lane_sel + 1'b1;
        end
      end else if (ready_in) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign lane_sel  = r_lane_sel;

endmodule

// File: tb/tb_byte_unstriping_n.sv
// Directed and randomized bench for byte_unstriping_n, checked against a
// queue-based reference model of the round-robin merge.
module tb_byte_unstriping_n;

  localparam int LANES = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic                   clk_f = 1'b0;
  logic                   reset = 1'b0;
  logic [LANES*WIDTH-1:0] lane_data = '0;
  logic [LANES-1:0]       lane_valid = '0;
  logic [3:0]             active_lanes = '0;
  logic                   ready_in = 1'b1;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [1:0]             lane_sel;
  logic [LANES-1:0]       overflow;

  byte_unstriping_n #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_f        (clk_f),
    .reset        (reset),
    .lane_data    (lane_data),
    .lane_valid   (lane_valid),
    .active_lanes (active_lanes),
    .ready_in     (ready_in),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .lane_sel     (lane_sel),
    .overflow     (overflow)
  );

  always #5 clk_f = ~clk_f;

  int checks   = 0;
  int failures = 0;

  // Reference model: one queue per lane plus the output register contents.
  logic [WIDTH-1:0] q [LANES][$];
  int               m_sel;
  int               m_act;
  bit               m_first;
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  logic [LANES-1:0] m_ovf;

  function automatic int dec(input int n);
    return (n == 0 || n > LANES) ? LANES : n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) q[i].delete();
    m_sel   = 0;
    m_act   = LANES;
    m_first = 1'b1;
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = '0;
  endtask

  // Advances the model by one edge using the inputs currently applied.
  task automatic model_step();
    int               act;
    bit               pop;
    logic [WIDTH-1:0] head;
    act  = m_first ? dec(int'(active_lanes)) : m_act;
    pop  = (q[m_sel].size() > 0) && (!m_valid || ready_in);
    head = '0;
    if (pop) head = q[m_sel].pop_front();
    for (int i = 0; i < act; i++) begin
      if (lane_valid[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(lane_data[i*WIDTH +: WIDTH]);
        else                     m_ovf[i] = 1'b1;
      end
    end
    if (m_first) m_act = act;
    m_first = 1'b0;
    if (pop) begin
      m_data  = head;
      m_valid = 1'b1;
      if (m_sel == act - 1) begin
        m_sel = 0;
        m_act = dec(int'(active_lanes));
      end else begin
        m_sel++;
      end
    end else if (ready_in) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".data"},     32'(data_out),  32'(m_data));
    check({tag, ".valid"},    32'(valid_out), 32'(m_valid));
    check({tag, ".lane_sel"}, 32'(lane_sel),  32'(m_sel));
    check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk_f);
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input logic [LANES-1:0] v, input logic [31:0] d);
    lane_valid = v;
    lane_data  = d;
  endtask

  task automatic apply_reset(input string tag);
    reset      = 1'b0;
    lane_valid = '0;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(posedge clk_f);
    #1;
    compare_all({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    #2;
    apply_reset("por");

    // Basic order on two active lanes.
    active_lanes = 4'd2;
    ready_in     = 1'b1;
    drive(4'b0011, 32'h0000_EEFF); tick("basic.p0");
    check("basic.lat1", 32'(valid_out), 32'd0);
    drive(4'b0011, 32'h0000_CCDD); tick("basic.p1");
    check("basic.b0", {31'd0, valid_out} << 8 | 32'(data_out), 32'h1FF);
    drive(4'b0000, 32'h0);
    tick("basic.i0"); check("basic.b1", 32'(data_out), 32'hEE);
    tick("basic.i1"); check("basic.b2", 32'(data_out), 32'hDD);
    tick("basic.i2"); check("basic.b3", 32'(data_out), 32'hCC);
    for (int i = 0; i < 3; i++) tick("basic.tail");

    // Skew: lane 3 arrives well ahead of lanes 0-2.
    apply_reset("skew.rst");
    active_lanes = 4'd4;
    drive(4'b1000, 32'h4400_0000); tick("skew.l3");
    drive(4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) tick("skew.wait");
    check("skew.stall", 32'(valid_out), 32'd0);
    drive(4'b0111, 32'h0033_2211); tick("skew.l012");
    drive(4'b0000, 32'h0);
    for (int i = 0; i < 6; i++) tick("skew.drain");

    // Backpressure mid-stream.
    apply_reset("bp.rst");
    drive(4'b1111, 32'h0403_0201); tick("bp.p0");
    drive(4'b1111, 32'h0807_0605); tick("bp.p1");
    drive(4'b0000, 32'h0);
    tick("bp.run");
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) tick("bp.stall");
    ready_in = 1'b1;
    for (int i = 0; i < 9; i++) tick("bp.drain");

    // Overflow on lane 1 while the output is blocked.
    apply_reset("ovf.rst");
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'b0010, 32'(8'hA0 + i) << 8);
      tick("ovf.push");
    end
    check("ovf.flag", 32'(overflow), 32'h2);
    ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1101, $urandom);
      tick("ovf.fill");
    end
    drive(4'b0000, 32'h0);
    for (int i = 0; i < 16; i++) tick("ovf.drain");
    check("ovf.sticky", 32'(overflow), 32'h2);

    // Mode: two of four lanes, then widen mid-round.
    apply_reset("mode.rst");
    active_lanes = 4'd2;
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, $urandom);
      tick("mode.push2");
    end
    active_lanes = 4'd4;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, $urandom);
      tick("mode.widen");
    end
    drive(4'b0000, 32'h0);
    for (int i = 0; i < 10; i++) tick("mode.drain");

    // Randomized traffic with backpressure and active-count changes.
    apply_reset("rnd.rst");
    for (int n = 0; n < 1500; n++) begin
      drive(LANES'($urandom), $urandom);
      ready_in = ($urandom_range(0, 3) != 0);
      if (n % 50 == 0) active_lanes = 4'($urandom_range(0, 15));
      tick("rnd");
    end

    // Reset with bytes buffered and the output valid.
    apply_reset("mid.rst0");
    active_lanes = 4'd4;
    ready_in     = 1'b1;
    drive(4'b1111, $urandom); tick("mid.fill");
    drive(4'b0000, 32'h0);    ready_in = 1'b0;
    tick("mid.hold");
    check("mid.valid_before", 32'(valid_out), 32'd1);
    apply_reset("mid.rst1");
    ready_in = 1'b1;
    drive(4'b0001, 32'h0000_005A); tick("mid.new");
    drive(4'b0000, 32'h0);
    tick("mid.out");
    check("mid.first", {31'd0, valid_out} << 8 | 32'(data_out), 32'h15A);
    for (int i = 0; i < 3; i++) tick("mid.tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_unstriping_n.md
Name: byte_unstriping_n

Overview:
- Parametrised successor to the two-lane byte un-striper.
- Merges LANES parallel byte lanes, each with its own valid, into one ordered output stream using strict round-robin lane order.
- Each lane has a small elastic FIFO, so lane bytes may arrive skewed in time.
- Adds downstream backpressure (ready_in), a runtime active-lane count, and per-lane sticky overflow flags.
- Sits between the per-lane receive logic and the byte-stream consumer, in one clock domain.

Parameters:
- LANES, 4, number of physical input lanes (2..8).
- WIDTH, 8, bits per lane word.
- DEPTH, 4, entries per lane FIFO (power of 2, at least 2).

Ports:
- clk_f  input  1  single clock; all logic is rising-edge.
- reset  input  1  asynchronous, active-low reset.
- lane_data  input  LANES*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- lane_valid  input  LANES  bit i high means lane i data is valid this cycle.
- active_lanes  input  4  number of lanes in use; 0 or values above LANES are treated as LANES.
- ready_in  input  1  downstream can accept data_out this cycle.
- data_out  output  WIDTH  merged byte stream.
- valid_out  output  1  data_out holds a valid byte.
- lane_sel  output  clog2(LANES)  lane the next output byte will be taken from.
- overflow  output  LANES  sticky per-lane FIFO overflow flag.

Behaviour:
- Reset (reset low, asynchronous):
  - All FIFO pointers and counts cleared.
  - lane_sel=0, data_out=0, valid_out=0, overflow=0.
  - Asserting reset mid-stream discards all buffered bytes immediately.
  - Release is synchronous to the next clk_f edge.
- Push:
  - On each edge, lane i with lane_valid[i]=1 and i < active lanes writes lane_data[i] into FIFO i.
  - Lanes i >= active lanes are ignored: no push, no overflow.
- Full FIFO:
  - A push to a full FIFO with no same-cycle pop from that FIFO drops the byte and sets overflow[i]. The flag stays set until reset.
  - A push and pop on a full FIFO in the same cycle is accepted; the count stays unchanged.
- Empty FIFO:
  - A pop reads an empty FIFO's write data only as a registered value; no combinational bypass.
  - A byte pushed at edge k is poppable at edge k+1 at the earliest.
- Output stage (one register; pop condition is FIFO[lane_sel] non-empty AND (valid_out=0 OR ready_in=1)):
  - On pop: data_out takes the FIFO head, valid_out=1, and lane_sel advances.
  - With no pop and ready_in=1: valid_out goes to 0; data_out holds its last value.
  - With valid_out=1 and ready_in=0: data_out, valid_out and lane_sel all hold.
- Ordering:
  - Lanes are never skipped. If FIFO[lane_sel] is empty, output stalls even when other lanes hold data.
  - Minimum latency is 2 edges from push to valid_out.
  - Throughput is 1 byte per cycle.
- Wrap:
  - lane_sel advances from (active-1) to 0, otherwise increments by 1.
- active_lanes:
  - Sampled only when lane_sel wraps to 0, and whenever reset is released.
  - The latched value governs both push masking and wrap.
  - Changing it mid-round takes effect at the next wrap.
- Simultaneous events: a push to lane_sel's FIFO in the same cycle it pops is legal.
- Counts are clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.

Test Plan:
- Basic order: LANES=2, active=2. Push lane0 FF and lane1 EE, then lane0 DD and lane1 CC, with ready_in=1 → data_out is FF,EE,DD,CC on consecutive valid cycles; valid_out first rises 2 edges after the first push.
- Skew: LANES=4. Lane3 pushes 44 four cycles before lanes 0-2 push 11,22,33 → output is 11,22,33,44 with no reordering; valid_out stays low while lane_sel=0 waits on an empty FIFO.
- Backpressure: stream 01..08 on 4 lanes with ready_in held low for 3 cycles mid-stream → data_out holds a stable value while stalled; no byte is lost or duplicated; overflow stays 0.
- Overflow: DEPTH=4, ready_in=0, lane1 pushes 5 bytes A0..A4 → overflow[1]=1 and A4 is dropped. After ready_in=1 the output is A0..A3 interleaved per round-robin; overflow[1] stays 1 until reset.
- Mode: active_lanes=2 on LANES=4. Pushes on lanes 2-3 are ignored and lane_sel toggles 0,1. active_lanes changed to 4 mid-round → takes effect only after lane_sel wraps to 0.
- Reset mid-stream: assert reset with 3 bytes buffered and valid_out=1 → valid_out, data_out, lane_sel and overflow go to 0 before the next edge. After release, the first output is the first byte pushed after release.
